// File: rtl/uart_tx_fifo_cfg_pkg.sv
// uart_tx_fifo_cfg_pkg: shared state and parity encodings for the configurable UART transmitter
package uart_tx_fifo_cfg_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
    typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD} parity_t;
endpackage

// File: rtl/uart_tx_fifo_cfg_if.sv
// uart_tx_fifo_cfg_if: valid/ready word stream feeding the transmitter FIFO
interface uart_tx_fifo_cfg_if #(parameter int DW = 8);
    logic [DW-1:0] data;
    logic          valid;
    logic          ready;
    modport master (output data, valid, input ready);
    modport slave  (input data, valid, output ready);
endinterface

// File: rtl/uart_tx_fifo_cfg_fifo.sv
// uart_tx_fifo_cfg_fifo: synchronous FIFO with wrap-bit pointers and show-ahead read
module uart_tx_fifo_cfg_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr, rd_ptr;
    assign empty = wr_ptr == rd_ptr;
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];
    // storage array, written only when there is room
    always_ff @(posedge clk)
        if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
    // pointers; a push into a full FIFO is dropped even if a pop happens on the same edge
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
endmodule

// File: rtl/uart_tx_fifo_cfg.sv
// uart_tx_fifo_cfg: FIFO-fed UART transmitter with runtime data/parity/stop/baud configuration
module uart_tx_fifo_cfg #(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    parameter int DIVW  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DIVW-1:0]     clkdiv,
    input  logic [1:0]          parity_mode,
    input  logic                stop2,
    uart_tx_fifo_cfg_if.slave   s,
    output logic                tx,
    output logic                tx_done,
    output logic                busy
);
    import uart_tx_fifo_cfg_pkg::*;
    localparam int BW = $clog2(DW);
    tx_state_t       state;
    logic [DIVW-1:0] baud_cnt, div_q;
    logic [BW-1:0]   bit_cnt;
    logic [DW-1:0]   shift, head;
    logic            par_en, par_bit, stop2_q, avail, full, empty, pop, bit_end, last_stop;
    parity_t         pmode;
    assign pmode     = parity_t'(parity_mode);
    assign bit_end   = baud_cnt == div_q;
    assign last_stop = bit_cnt == BW'(stop2_q);
    assign pop       = !empty && ((state == IDLE && avail) || (state == STOP && bit_end && last_stop));
    assign s.ready   = !full;
    assign busy      = (state != IDLE) || !empty;

    uart_tx_fifo_cfg_fifo #(.W(DW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (s.valid),
        .pop   (pop),
        .din   (s.data),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    // frame sequencer: tx and tx_done are registered, so tx_done is raised on the edge that enters the last stop cycle
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state    <= IDLE;
            tx       <= 1'b1;
            tx_done  <= 1'b0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            div_q    <= '0;
            par_en   <= 1'b0;
            par_bit  <= 1'b0;
            stop2_q  <= 1'b0;
            avail    <= 1'b0;
        end else begin
            avail   <= !empty;
            tx_done <= 1'b0;
            if (state != IDLE) baud_cnt <= bit_end ? '0 : baud_cnt + DIVW'(1);
            case (state)
                START:
                    if (bit_end) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                        tx      <= shift[0];
                    end
                DATA:
                    if (bit_end) begin
                        if (bit_cnt == BW'(DW - 1)) begin
                            state   <= par_en ? PARITY : STOP;
                            tx      <= par_en ? par_bit : 1'b1;
                            bit_cnt <= '0;
                            tx_done <= !par_en && div_q == '0 && !stop2_q;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            shift   <= shift >> 1;
                            tx      <= shift[1];
                        end
                    end
                PARITY:
                    if (bit_end) begin
                        state   <= STOP;
                        tx      <= 1'b1;
                        tx_done <= div_q == '0 && !stop2_q;
                    end
                STOP:
                    if (bit_end) begin
                        if (last_stop) state <= IDLE;
                        else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            tx_done <= div_q == '0;
                        end
                    end else tx_done <= last_stop && (baud_cnt + DIVW'(1) == div_q);
                default: ;
            endcase
            if (pop) begin
                state    <= START;
                tx       <= 1'b0;
                baud_cnt <= '0;
                shift    <= head;
                div_q    <= clkdiv;
                stop2_q  <= stop2;
                par_en   <= pmode == PAR_EVEN || pmode == PAR_ODD;
                par_bit  <= pmode == PAR_ODD ? ~^head : ^head;
            end
        end
endmodule

// File: tb/tb_uart_tx_fifo_cfg.sv
// tb_uart_tx_fifo_cfg: directed self-checking bench for the configurable UART transmitter
module tb_uart_tx_fifo_cfg;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] clkdiv = 16'd3;
    logic [1:0]  parity_mode = 2'b00;
    logic        stop2 = 1'b0;
    logic        tx, tx_done, busy;
    int          n_chk = 0;
    int          n_pass = 0;

    uart_tx_fifo_cfg_if #(.DW(8)) sif ();

    uart_tx_fifo_cfg #(.DW(8), .DEPTH(4), .DIVW(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .clkdiv      (clkdiv),
        .parity_mode (parity_mode),
        .stop2       (stop2),
        .s           (sif.slave),
        .tx          (tx),
        .tx_done     (tx_done),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic push(input logic [7:0] w);
        sif.data  = w;
        sif.valid = 1'b1;
        @(negedge clk);
        sif.valid = 1'b0;
    endtask

    // waits for a start bit, then checks every cycle of one frame; seq holds the first sample of each bit
    task automatic frame(input string tag, input logic [7:0] w, input int div, input bit pen,
                         input bit podd, input bit st2, output int wc, output logic [11:0] seq,
                         output int done_at);
        int nb, len, err, derr, b;
        logic [11:0] eb;
        nb = 10 + int'(pen) + int'(st2);
        len = nb * (div + 1);
        err = 0;
        derr = 0;
        eb = '1;
        eb[0] = 1'b0;
        for (int i = 0; i < 8; i++) eb[i+1] = w[i];
        if (pen) eb[9] = podd ? ~^w : ^w;
        seq = '1;
        done_at = 0;
        wc = 0;
        do begin
            @(negedge clk);
            wc++;
        end while (tx !== 1'b0 && wc < 100);
        chk({tag, " start"}, {31'd0, tx}, 32'd0);
        if (tx === 1'b0) begin
            for (int c = 0; c < len; c++) begin
                if (c > 0) @(negedge clk);
                b = c / (div + 1);
                if (c % (div + 1) == 0) seq[b] = tx;
                if (tx !== eb[b]) err++;
                if (tx_done === 1'b1 && done_at == 0) done_at = c + 1;
                if (tx_done !== (c == len - 1)) derr++;
            end
        end
        chk({tag, " bits"}, err, 0);
        chk({tag, " done pulse"}, derr, 0);
    endtask

    initial begin
        int wc, da, acc, lows, bsy;
        logic [11:0] seq;
        int wcs[5], das[5];
        logic [11:0] seqs[5];
        logic [7:0] wl[6];
        wl = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        sif.valid = 1'b0;
        sif.data  = '0;
        repeat (3) @(negedge clk);
        chk("reset tx", {31'd0, tx}, 32'd1);
        chk("reset tx_done", {31'd0, tx_done}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset ready", {31'd0, sif.ready}, 32'd1);
        rst = 1'b1;
        @(negedge clk);

        push(8'hA5);
        frame("t1", 8'hA5, 3, 0, 0, 0, wc, seq, da);
        chk("t1 latency", wc, 2);
        chk("t1 seq", {22'd0, seq[9:0]}, {22'd0, 10'b1101001010});
        chk("t1 done_at", da, 40);
        @(negedge clk);
        chk("t1 idle busy", {31'd0, busy}, 32'd0);
        chk("t1 idle tx", {31'd0, tx}, 32'd1);

        parity_mode = 2'b01;
        push(8'hA5);
        frame("t2e", 8'hA5, 3, 1, 0, 0, wc, seq, da);
        chk("t2e parity", {31'd0, seq[9]}, 32'd0);
        chk("t2e done_at", da, 44);
        @(negedge clk);
        parity_mode = 2'b10;
        push(8'hA5);
        frame("t2o", 8'hA5, 3, 1, 1, 0, wc, seq, da);
        chk("t2o parity", {31'd0, seq[9]}, 32'd1);
        chk("t2o done_at", da, 44);
        @(negedge clk);
        parity_mode = 2'b11;
        push(8'hA5);
        frame("t2n", 8'hA5, 3, 0, 0, 0, wc, seq, da);
        chk("t2n done_at", da, 40);
        @(negedge clk);

        parity_mode = 2'b00;
        stop2 = 1'b1;
        push(8'h00);
        frame("t3", 8'h00, 3, 0, 0, 1, wc, seq, da);
        chk("t3 seq", {21'd0, seq[10:0]}, {21'd0, 11'b11000000000});
        chk("t3 done_at", da, 44);
        stop2 = 1'b0;
        @(negedge clk);

        clkdiv = 16'd1;
        acc = 0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    sif.data  = wl[i];
                    sif.valid = 1'b1;
                    if (sif.ready) acc++;
                    if (i == 5) chk("t4 ready on 6th", {31'd0, sif.ready}, 32'd0);
                    @(negedge clk);
                end
                sif.valid = 1'b0;
            end
            begin
                for (int i = 0; i < 5; i++) frame("t4", wl[i], 1, 0, 0, 0, wcs[i], seqs[i], das[i]);
            end
        join
        chk("t4 accepted", acc, 5);
        for (int i = 0; i < 5; i++) begin
            chk("t4 word", {24'd0, seqs[i][8:1]}, {24'd0, wl[i]});
            chk("t4 done_at", das[i], 20);
            if (i > 0) chk("t4 gap", wcs[i], 1);
        end
        @(negedge clk);
        chk("t4 busy after", {31'd0, busy}, 32'd0);
        lows = 0;
        repeat (20) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        chk("t4 no 6th frame", lows, 0);

        clkdiv = 16'd3;
        push(8'h3C);
        push(8'h5A);
        push(8'h96);
        repeat (10) @(negedge clk);
        chk("t5 busy before", {31'd0, busy}, 32'd1);
        chk("t5 tx low mid-data", {31'd0, tx}, 32'd0);
        rst = 1'b0;
        #1;
        chk("t5 async tx", {31'd0, tx}, 32'd1);
        chk("t5 async ready", {31'd0, sif.ready}, 32'd1);
        chk("t5 async busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        lows = 0;
        bsy = 0;
        repeat (40) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
            if (busy !== 1'b0) bsy++;
        end
        chk("t5 tx stays high", lows, 0);
        chk("t5 no busy", bsy, 0);

        fork
            begin
                push(8'h0F);
                push(8'hF0);
                repeat (12) @(negedge clk);
                clkdiv = 16'd1;
            end
            begin
                frame("t6a", 8'h0F, 3, 0, 0, 0, wcs[0], seqs[0], das[0]);
                frame("t6b", 8'hF0, 1, 0, 0, 0, wcs[1], seqs[1], das[1]);
            end
        join
        chk("t6 first done_at", das[0], 40);
        chk("t6 gap", wcs[1], 1);
        chk("t6 second done_at", das[1], 20);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
